// File: rtl/game_pkg.sv
// Shared definitions for the dino game sequencer: state codes, widths and
// the lives-to-LED thermometer mapping.
package game_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned LED_W   = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd1;
    localparam logic [STATE_W-1:0] ST_HIT    = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSED = 3'd3;
    localparam logic [STATE_W-1:0] ST_OVER   = 3'd4;

    function automatic logic [LED_W-1:0] lives_to_leds(input logic [LIVES_W-1:0] lives);
        logic [LED_W-1:0] leds;
        leds = '0;
        case (lives)
            2'd1:    leds = 3'b001;
            2'd2:    leds = 3'b011;
            2'd3:    leds = 3'b111;
            default: leds = 3'b000;
        endcase
        return leds;
    endfunction

    // RUN and HIT are the states where the game is actually advancing.
    function automatic logic is_active(input logic [STATE_W-1:0] st);
        return (st == ST_RUN) || (st == ST_HIT);
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Board-side inputs and game-control outputs of the dino game sequencer.
interface game_state_controller_if;

    logic                         frame_clk;
    logic                         button_raw;
    logic                         pause_switch;
    logic                         collision;
    logic                         frame_step;
    logic                         jump_req;
    logic                         run_en;
    logic                         game_over;
    logic [game_pkg::LIVES_W-1:0] lives;
    logic [game_pkg::LED_W-1:0]   life_leds;
    logic                         hit_flash;
    logic [game_pkg::STATE_W-1:0] state;

    modport slave (
        input  frame_clk, button_raw, pause_switch, collision,
        output frame_step, jump_req, run_en, game_over, lives, life_leds, hit_flash, state
    );

    modport master (
        output frame_clk, button_raw, pause_switch, collision,
        input  frame_step, jump_req, run_en, game_over, lives, life_leds, hit_flash, state
    );

endinterface

// File: rtl/game_state_controller_sync.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse
// on its synchronised rising edge.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= s1 & ~s2;
        end
    end

    assign level = s2;

endmodule

// File: rtl/game_state_controller.sv
// Dino game sequencer: conditions board inputs, runs the idle/run/hit/pause/over
// FSM and owns the lives counter and invulnerability window.
module game_state_controller
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned INVULN_FRAMES   = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic                    clk,
    input logic                    reset,
    game_state_controller_if.slave bus
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned INV_W = 8;

    logic frame_lvl, frame_edge, btn_lvl, btn_rise;
    logic pause_lvl, pause_rise, coll_lvl, coll_edge;

    sync_edge_detect u_sync_frame (.clk(clk), .reset(reset), .din(bus.frame_clk),    .level(frame_lvl), .rise(frame_edge));
    sync_edge_detect u_sync_btn   (.clk(clk), .reset(reset), .din(bus.button_raw),   .level(btn_lvl),   .rise(btn_rise));
    sync_edge_detect u_sync_pause (.clk(clk), .reset(reset), .din(bus.pause_switch), .level(pause_lvl), .rise(pause_rise));
    sync_edge_detect u_sync_coll  (.clk(clk), .reset(reset), .din(bus.collision),    .level(coll_lvl),  .rise(coll_edge));

    logic unused_sync;
    assign unused_sync = ^{frame_lvl, btn_rise, pause_rise, coll_lvl};

    // Debounce: the level only follows the button after it has disagreed for a full window.
    logic [DB_W-1:0] db_cnt;
    logic            db_lvl;
    logic            press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt <= '0;
            db_lvl <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_lvl == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt <= '0;
                db_lvl <= btn_lvl;
                press  <= btn_lvl;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    logic [STATE_W-1:0] state_q, state_nx, ret_q, ret_nx;
    logic [LIVES_W-1:0] lives_q, lives_nx;
    logic [INV_W-1:0]   inv_q, inv_nx;
    logic               flash_q, flash_nx;
    logic               active;

    assign active = is_active(state_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            lives_q <= '0;
            inv_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            ret_q   <= ret_nx;
            lives_q <= lives_nx;
            inv_q   <= inv_nx;
            flash_q <= flash_nx;
        end
    end

    // Collision outranks pause, which outranks the button.
    always_comb begin
        state_nx = state_q;
        ret_nx   = ret_q;
        lives_nx = lives_q;
        inv_nx   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_nx = ST_RUN;
                    lives_nx = LIVES_W'(LIVES_INIT);
                end
            end
            ST_RUN: begin
                if (coll_edge) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        state_nx = ST_OVER;
                        lives_nx = '0;
                    end else begin
                        state_nx = ST_HIT;
                        lives_nx = lives_q - LIVES_W'(1);
                        inv_nx   = INV_W'(INVULN_FRAMES);
                    end
                end else if (pause_lvl) begin
                    state_nx = ST_PAUSED;
                    ret_nx   = ST_RUN;
                end
            end
            ST_HIT: begin
                if (pause_lvl) begin
                    state_nx = ST_PAUSED;
                    ret_nx   = ST_HIT;
                end else if (frame_edge) begin
                    if (inv_q <= INV_W'(1)) begin
                        state_nx = ST_RUN;
                        inv_nx   = '0;
                    end else begin
                        inv_nx = inv_q - INV_W'(1);
                    end
                end
            end
            ST_PAUSED: begin
                if (!pause_lvl) begin
                    state_nx = ret_q;
                end
            end
            ST_OVER: begin
                lives_nx = '0;
                if (press) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        flash_nx = (state_nx == ST_HIT) ? (flash_q ^ ((state_q == ST_HIT) && frame_edge)) : 1'b0;
    end

    // Status outputs are registered from next-state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.frame_step <= 1'b0;
            bus.jump_req   <= 1'b0;
            bus.run_en     <= 1'b0;
            bus.game_over  <= 1'b0;
            bus.life_leds  <= '0;
        end else begin
            bus.frame_step <= frame_edge & active;
            bus.jump_req   <= press & active;
            bus.run_en     <= is_active(state_nx);
            bus.game_over  <= (state_nx == ST_OVER);
            bus.life_leds  <= lives_to_leds(lives_nx);
        end
    end

    assign bus.state     = state_q;
    assign bus.lives     = lives_q;
    assign bus.hit_flash = flash_q;

endmodule
